// File: rtl/sm4_pkg.sv
// SM4 key-schedule constants: FK words, CK generator, S-box lookup and FSM state type.
package sm4_pkg;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} sm4_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Byte j of CK_i is (4i+j)*7 mod 256, most significant byte first.
    function automatic logic [31:0] sm4_ck(input logic [4:0] idx);
        logic [31:0] w;
        logic [7:0]  n;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, idx, 2'(j)};
            w[31-8*j -: 8] = n * 8'd7;
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: rk = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK).
module sm4_key_round
    import sm4_pkg::*;
(
    input  logic [31:0] k0_i,
    input  logic [31:0] k1_i,
    input  logic [31:0] k2_i,
    input  logic [31:0] k3_i,
    input  logic [31:0] ck_i,
    output logic [31:0] rk_o
);

    logic [31:0] mix;
    logic [31:0] sub;

    assign mix = k1_i ^ k2_i ^ k3_i ^ ck_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub[8*b +: 8] = sm4_sbox(mix[8*b +: 8]);
    end

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign rk_o = k0_i ^ sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};

endmodule

// File: rtl/sm4_key_sched.sv
// SM4 round-key scheduler, UNROLL rounds per clock, 32 round keys held in slots.
// Optional SM4_KEY_ZEROIZE_EN adds a synchronous zeroize of all key material.
module sm4_key_sched
    import sm4_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [127:0]  key,
    input  logic          dec,
    input  logic          zeroize,
    output logic          busy,
    output logic          rk_valid,
    output logic [1023:0] rk
);

    localparam logic [4:0] CNT_LAST = 5'(32 - UNROLL);
    localparam logic [4:0] CNT_STEP = 5'(UNROLL);

    sm4_state_e  state_q, state_d;
    logic [31:0] k_q    [4];
    logic [31:0] slot_q [32];
    logic [4:0]  cnt_q;
    logic        dec_q;
    logic        rkv_q;
    logic        accept;
    logic        last_step;
    logic [31:0] kw     [UNROLL+4];
    logic [4:0]  wr_idx [UNROLL];

`ifndef SM4_KEY_ZEROIZE_EN
    logic unused_zeroize;
    assign unused_zeroize = zeroize;
`endif

    assign key_ready = (state_q != ST_EXPAND);
    assign busy      = (state_q == ST_EXPAND);
    assign accept    = key_valid && key_ready;
    assign last_step = (cnt_q == CNT_LAST);
    assign rk_valid  = rkv_q;

    // kw[0..3] is the current window; kw[4+g] is the key produced by round g this cycle.
    for (genvar j = 0; j < 4; j++) begin : g_window
        assign kw[j] = k_q[j];
    end

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [4:0]  rnd;
        logic [31:0] ck_w;
        assign rnd  = cnt_q + 5'(g);
        assign ck_w = sm4_ck(rnd);
        assign wr_idx[g] = dec_q ? ~rnd : rnd;
        sm4_key_round u_round (
            .k0_i (kw[g]),
            .k1_i (kw[g+1]),
            .k2_i (kw[g+2]),
            .k3_i (kw[g+3]),
            .ck_i (ck_w),
            .rk_o (kw[g+4])
        );
    end

    for (genvar s = 0; s < 32; s++) begin : g_out
        assign rk[1023-32*s -: 32] = slot_q[s];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_EXPAND;
            ST_EXPAND: if (last_step) state_d = ST_DONE;
            ST_DONE:   if (accept)    state_d = ST_EXPAND;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
`ifdef SM4_KEY_ZEROIZE_EN
        end else if (zeroize) begin
            state_q <= ST_IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < 4; j++) k_q[j] <= '0;
            for (int s = 0; s < 32; s++) slot_q[s] <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
            rkv_q <= 1'b0;
`ifdef SM4_KEY_ZEROIZE_EN
        end else if (zeroize) begin
            for (int j = 0; j < 4; j++) k_q[j] <= '0;
            for (int s = 0; s < 32; s++) slot_q[s] <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
            rkv_q <= 1'b0;
`endif
        end else if (accept) begin
            k_q[0] <= key[127:96] ^ FK0;
            k_q[1] <= key[95:64]  ^ FK1;
            k_q[2] <= key[63:32]  ^ FK2;
            k_q[3] <= key[31:0]   ^ FK3;
            cnt_q  <= '0;
            dec_q  <= dec;
            rkv_q  <= 1'b0;
        end else if (state_q == ST_EXPAND) begin
            for (int j = 0; j < 4; j++) k_q[j] <= kw[UNROLL+j];
            for (int u = 0; u < UNROLL; u++) slot_q[wr_idx[u]] <= kw[u+4];
            cnt_q <= cnt_q + CNT_STEP;
            rkv_q <= last_step;
        end
    end

endmodule
